// File: rtl/duck_spawn_gen.sv
// duck_spawn_gen: turns a free-running 16-bit RNG stream into a legal duck spawn
// (x, y, heading, speed) on request from the game FSM.
// Ports:
//   clk, reset (sync, active-low)  | rng_value[15:0] new random word every cycle
//   spawn_req / spawn_ack          | request handshake from the game FSM
//   duck_x/duck_y[9:0], duck_dir[1:0], duck_speed[2:0], spawn_valid, busy
// Latency: req seen at E0 -> spawn_valid after E3, plus one cycle per x rejection.
// Backpressure: results hold in VALID until spawn_ack; req ignored while busy.
module duck_spawn_gen #(
  parameter int X_MAX     = 608,
  parameter int Y_MIN     = 32,
  parameter int MAX_RETRY = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rng_value,
  input  logic        spawn_req,
  input  logic        spawn_ack,
  output logic [9:0]  duck_x,
  output logic [9:0]  duck_y,
  output logic [1:0]  duck_dir,
  output logic [2:0]  duck_speed,
  output logic        spawn_valid,
  output logic        busy
);

  // Retry counter is at least 3 bits wide and wide enough to hold MAX_RETRY.
  localparam int RW = ($clog2(MAX_RETRY + 1) < 3) ? 3 : $clog2(MAX_RETRY + 1);
  localparam logic [9:0]    X_MAX_L    = X_MAX[9:0];
  localparam logic [9:0]    Y_MIN_L    = Y_MIN[9:0];
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE_X,
    S_SAMPLE_Y,
    S_SAMPLE_D,
    S_VALID
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [RW-1:0] r_retry;
  logic [RW-1:0] w_retry_nxt;
  logic [9:0]    r_duck_x,     w_duck_x_nxt;
  logic [9:0]    r_duck_y,     w_duck_y_nxt;
  logic [1:0]    r_duck_dir,   w_duck_dir_nxt;
  logic [2:0]    r_duck_speed, w_duck_speed_nxt;
  logic          r_spawn_valid;

  logic          w_x_ok;
  logic [2:0]    w_speed_raw;
  logic          w_unused;

  // Only the low 10 bits of the RNG word are ever consumed.
  assign w_unused    = ^rng_value[15:10];
  assign w_x_ok      = (rng_value[9:0] <= X_MAX_L);
  assign w_speed_raw = rng_value[4:2];

  always_comb begin
    w_state_nxt      = r_state;
    w_retry_nxt      = r_retry;
    w_duck_x_nxt     = r_duck_x;
    w_duck_y_nxt     = r_duck_y;
    w_duck_dir_nxt   = r_duck_dir;
    w_duck_speed_nxt = r_duck_speed;

    unique case (r_state)
      S_IDLE: begin
        if (spawn_req) begin
          w_state_nxt = S_SAMPLE_X;
        end
      end
      S_SAMPLE_X: begin
        if (w_x_ok) begin
          w_duck_x_nxt = rng_value[9:0];
          w_retry_nxt  = '0;
          w_state_nxt  = S_SAMPLE_Y;
        end else if (r_retry == RETRY_LAST) begin
          // Out of retries: a 9-bit value is always on screen, so take it as-is.
          w_duck_x_nxt = {1'b0, rng_value[8:0]};
          w_retry_nxt  = '0;
          w_state_nxt  = S_SAMPLE_Y;
        end else begin
          w_retry_nxt  = r_retry + 1'b1;
        end
      end
      S_SAMPLE_Y: begin
        w_duck_y_nxt = Y_MIN_L + {2'b00, rng_value[7:0]};
        w_state_nxt  = S_SAMPLE_D;
      end
      S_SAMPLE_D: begin
        w_duck_dir_nxt   = rng_value[1:0];
        // A stationary duck is not allowed; speed 0 is promoted to 1.
        w_duck_speed_nxt = (w_speed_raw == 3'd0) ? 3'd1 : w_speed_raw;
        w_state_nxt      = S_VALID;
      end
      S_VALID: begin
        // Ack wins over a concurrent req; the req is not remembered.
        if (spawn_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_retry_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_retry       <= '0;
      r_duck_x      <= '0;
      r_duck_y      <= '0;
      r_duck_dir    <= 2'b00;
      r_duck_speed  <= 3'd1;
      r_spawn_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_retry       <= w_retry_nxt;
      r_duck_x      <= w_duck_x_nxt;
      r_duck_y      <= w_duck_y_nxt;
      r_duck_dir    <= w_duck_dir_nxt;
      r_duck_speed  <= w_duck_speed_nxt;
      // Registered copy of "next state is VALID" so it tracks the state exactly.
      r_spawn_valid <= (w_state_nxt == S_VALID);
    end
  end

  assign duck_x      = r_duck_x;
  assign duck_y      = r_duck_y;
  assign duck_dir    = r_duck_dir;
  assign duck_speed  = r_duck_speed;
  assign spawn_valid = r_spawn_valid;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_duck_spawn_gen.sv
module tb_duck_spawn_gen;

  logic        clk;
  logic        reset;
  logic [15:0] rng_value;
  logic        spawn_req;
  logic        spawn_ack;
  logic [9:0]  duck_x;
  logic [9:0]  duck_y;
  logic [1:0]  duck_dir;
  logic [2:0]  duck_speed;
  logic        spawn_valid;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  duck_spawn_gen dut (
    .clk        (clk),
    .reset      (reset),
    .rng_value  (rng_value),
    .spawn_req  (spawn_req),
    .spawn_ack  (spawn_ack),
    .duck_x     (duck_x),
    .duck_y     (duck_y),
    .duck_dir   (duck_dir),
    .duck_speed (duck_speed),
    .spawn_valid(spawn_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse spawn_req at E0, then present v[0..n-1] at E1..En.
  // early is set if spawn_valid rose before the last value was consumed.
  task automatic feed(input logic [15:0] v[16], input int n, output logic early);
    early     = 1'b0;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      rng_value = v[i];
      tick();
      if (i < n - 1 && spawn_valid) early = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; spawn_req = 1'b1; spawn_ack = 1'b0; rng_value = 16'hFFFF;
    tick(); tick();
    n_total++;
    if ({busy, spawn_valid, duck_x, duck_y, duck_dir, duck_speed} !== {1'b0, 1'b0, 10'd0, 10'd0, 2'b00, 3'd1}) begin
      $display("FAIL reset_state: got busy=%b vld=%b x=%0d y=%0d dir=%b spd=%0d, want 0 0 0 0 00 1",
               busy, spawn_valid, duck_x, duck_y, duck_dir, duck_speed);
    end else n_pass++;
    reset = 1'b1; spawn_req = 1'b0;
    tick();
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_req_dropped: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    spawn_req = 1'b1; rng_value = 16'h0000;
    tick();                                   // E0
    spawn_req = 1'b0;
    n_total++;
    if ({busy, spawn_valid} !== 2'b10) $display("FAIL basic_busy_e0: busy=%b vld=%b want 1 0", busy, spawn_valid);
    else n_pass++;
    spawn_ack = 1'b1;                         // ack outside VALID must be ignored
    rng_value = 16'h0123; tick();             // E1
    rng_value = 16'h0040; tick();             // E2
    n_total++;
    if (spawn_valid !== 1'b0) $display("FAIL basic_vld_e2: vld=%b want 0", spawn_valid);
    else n_pass++;
    spawn_ack = 1'b0;
    rng_value = 16'h0011; tick();             // E3
    n_total++;
    if ({spawn_valid, busy, duck_x, duck_y, duck_dir, duck_speed} !== {1'b1, 1'b1, 10'h123, 10'd96, 2'b01, 3'd4})
      $display("FAIL basic_result: vld=%b busy=%b x=%0d y=%0d dir=%b spd=%0d want 1 1 291 96 01 4",
               spawn_valid, busy, duck_x, duck_y, duck_dir, duck_speed);
    else n_pass++;
    spawn_ack = 1'b1; tick(); spawn_ack = 1'b0;
    n_total++;
    if ({spawn_valid, busy, duck_x} !== {1'b0, 1'b0, 10'h123})
      $display("FAIL basic_ack: vld=%b busy=%b x=%0d want 0 0 291", spawn_valid, busy, duck_x);
    else n_pass++;
  endtask

  task automatic test_rejection();
    logic [15:0] v[16];
    logic early;
    v = '{default: 16'h0};
    v[0] = 16'h03FF; v[1] = 16'h0300; v[2] = 16'h0100; v[3] = 16'h0005; v[4] = 16'h0000;
    feed(v, 5, early);
    n_total++;
    if ({early, spawn_valid} !== 2'b01) $display("FAIL reject_latency: early=%b vld=%b want 0 1", early, spawn_valid);
    else n_pass++;
    n_total++;
    if ({duck_x, duck_y, duck_dir, duck_speed} !== {10'd256, 10'd37, 2'b00, 3'd1})
      $display("FAIL reject_result: x=%0d y=%0d dir=%b spd=%0d want 256 37 00 1", duck_x, duck_y, duck_dir, duck_speed);
    else n_pass++;
    spawn_ack = 1'b1; tick(); spawn_ack = 1'b0;
  endtask

  task automatic test_fallback();
    logic [15:0] v[16];
    logic early;
    v = '{default: 16'hFFFF};
    feed(v, 10, early);
    n_total++;
    if ({early, spawn_valid} !== 2'b01) $display("FAIL fallback_latency: early=%b vld=%b want 0 1", early, spawn_valid);
    else n_pass++;
    n_total++;
    if ({duck_x, duck_y, duck_dir, duck_speed} !== {10'd511, 10'd287, 2'b11, 3'd7})
      $display("FAIL fallback_result: x=%0d y=%0d dir=%b spd=%0d want 511 287 11 7", duck_x, duck_y, duck_dir, duck_speed);
    else n_pass++;
  endtask

  // Continues from the VALID state left by test_fallback.
  task automatic test_hold_and_ack();
    for (int i = 0; i < 20; i++) begin
      rng_value = 16'($urandom);
      spawn_req = i[0];
      tick();
      n_total++;
      if ({spawn_valid, duck_x, duck_y, duck_dir, duck_speed} !== {1'b1, 10'd511, 10'd287, 2'b11, 3'd7})
        $display("FAIL hold_cycle%0d: vld=%b x=%0d y=%0d dir=%b spd=%0d want 1 511 287 11 7",
                 i, spawn_valid, duck_x, duck_y, duck_dir, duck_speed);
      else n_pass++;
    end
    spawn_req = 1'b1; spawn_ack = 1'b1;
    tick();
    spawn_req = 1'b0; spawn_ack = 1'b0;
    n_total++;
    if ({spawn_valid, busy} !== 2'b00) $display("FAIL ack_with_req: vld=%b busy=%b want 0 0", spawn_valid, busy);
    else n_pass++;
    tick();
    n_total++;
    if ({busy, duck_x, duck_y} !== {1'b0, 10'd511, 10'd287})
      $display("FAIL idle_retain: busy=%b x=%0d y=%0d want 0 511 287", busy, duck_x, duck_y);
    else n_pass++;
  endtask

  // 6 rejects, 609 rejected as 7th, 608 accepted on the last allowed try.
  task automatic test_boundary();
    logic [15:0] v[16];
    logic early;
    v = '{default: 16'h03FF};
    v[6] = 16'h0261; v[7] = 16'h0260; v[8] = 16'h0000; v[9] = 16'h001C;
    feed(v, 10, early);
    n_total++;
    if ({early, spawn_valid} !== 2'b01) $display("FAIL boundary_latency: early=%b vld=%b want 0 1", early, spawn_valid);
    else n_pass++;
    n_total++;
    if ({duck_x, duck_y, duck_dir, duck_speed} !== {10'd608, 10'd32, 2'b00, 3'd7})
      $display("FAIL boundary_result: x=%0d y=%0d dir=%b spd=%0d want 608 32 00 7", duck_x, duck_y, duck_dir, duck_speed);
    else n_pass++;
    spawn_ack = 1'b1; tick(); spawn_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] v[16];
    logic early;
    spawn_req = 1'b1; tick();                 // E0 -> SAMPLE_X
    spawn_req = 1'b0; rng_value = 16'h0123; tick();  // E1 -> SAMPLE_Y
    reset = 1'b0; spawn_req = 1'b1;
    tick();
    n_total++;
    if ({busy, spawn_valid, duck_x} !== {1'b0, 1'b0, 10'd0})
      $display("FAIL reset_mid: busy=%b vld=%b x=%0d want 0 0 0", busy, spawn_valid, duck_x);
    else n_pass++;
    reset = 1'b1; spawn_req = 1'b0;
    tick();
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_mid_idle: busy=%b want 0", busy);
    else n_pass++;
    v = '{default: 16'h0};
    v[0] = 16'h0123; v[1] = 16'h0040; v[2] = 16'h0011;
    feed(v, 3, early);
    n_total++;
    if ({early, spawn_valid, duck_x, duck_y, duck_dir, duck_speed} !== {1'b0, 1'b1, 10'h123, 10'd96, 2'b01, 3'd4})
      $display("FAIL reset_mid_respawn: early=%b vld=%b x=%0d y=%0d dir=%b spd=%0d want 0 1 291 96 01 4",
               early, spawn_valid, duck_x, duck_y, duck_dir, duck_speed);
    else n_pass++;
    spawn_ack = 1'b1; tick(); spawn_ack = 1'b0;
  endtask

  task automatic test_soak();
    logic [15:0] x;
    int k;
    x = 16'hACE1;
    for (int s = 0; s < 2000; s++) begin
      spawn_req = 1'b1;
      x = x ^ (x << 7); x = x ^ (x >> 9); x = x ^ (x << 8);
      rng_value = x;
      tick();
      spawn_req = 1'b0;
      k = 0;
      while (!spawn_valid && k < 20) begin
        x = x ^ (x << 7); x = x ^ (x >> 9); x = x ^ (x << 8);
        rng_value = x;
        tick();
        k++;
      end
      n_total++;
      if (!(spawn_valid === 1'b1 && k <= 10 && duck_x <= 10'd608 && duck_y >= 10'd32 && duck_y <= 10'd287 &&
            duck_speed >= 3'd1 && duck_speed <= 3'd7))
        $display("FAIL soak_spawn%0d: vld=%b cycles=%0d x=%0d y=%0d spd=%0d want vld 1 cycles<=10 x<=608 y 32..287 spd 1..7",
                 s, spawn_valid, k, duck_x, duck_y, duck_speed);
      else n_pass++;
      spawn_ack = 1'b1; tick(); spawn_ack = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0; spawn_req = 1'b0; spawn_ack = 1'b0; rng_value = 16'h0;
    test_reset();
    test_basic();
    test_rejection();
    test_fallback();
    test_hold_and_ack();
    test_boundary();
    test_reset_mid();
    test_soak();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/duck_spawn_gen.md
DUCK_SPAWN_GEN -- requirements
Module: duck_spawn_gen

Interface
REQ-001 Parameter X_MAX, default 608: largest legal duck x (640-pixel screen minus 32-pixel sprite).
REQ-002 Parameter Y_MIN, default 32: smallest legal duck y; y span is fixed at 256 lines.
REQ-003 Parameter MAX_RETRY, default 8: x-rejection attempts before fallback.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-006 rng_value  input  16  free-running output of xorshift_rng; new value every clk.
REQ-007 spawn_req  input  1  game FSM request for a new duck; level or pulse.
REQ-008 spawn_ack  input  1  game FSM has latched the spawn outputs.
REQ-009 duck_x  output  10  spawn x coordinate.
REQ-010 duck_y  output  10  spawn y coordinate.
REQ-011 duck_dir  output  2  initial heading: 00 up-left, 01 up-right, 10 left, 11 right.
REQ-012 duck_speed  output  3  pixels per frame, range 1..7.
REQ-013 spawn_valid  output  1  duck_x/y/dir/speed valid and stable.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, SAMPLE_X, SAMPLE_Y, SAMPLE_D, VALID; encoding free.
REQ-016 IDLE: spawn_req=1 at an edge -> SAMPLE_X; spawn_req is ignored in every other state.
REQ-017 SAMPLE_X: at the edge, candidate = rng_value[9:0]; if candidate <= X_MAX, load duck_x, clear retry count, -> SAMPLE_Y.
REQ-018 SAMPLE_X reject (candidate > X_MAX): increment 3-bit-or-wider retry count, stay in SAMPLE_X.
REQ-019 When the MAX_RETRY-th consecutive candidate is rejected, duck_x SHALL load {1'b0, rng_value[8:0]} (0..511) at that same edge and -> SAMPLE_Y; no further retries.
REQ-020 SAMPLE_Y: at the edge, duck_y = Y_MIN + rng_value[7:0] (10-bit unsigned, no overflow for Y_MIN <= 223), -> SAMPLE_D.
REQ-021 SAMPLE_D: at the edge, duck_dir = rng_value[1:0]; duck_speed = rng_value[4:2], with 0 replaced by 1; -> VALID.
REQ-022 Each sample state SHALL consume rng_value of its own cycle; no value is used twice.
REQ-023 spawn_valid SHALL be registered, 1 exactly while in VALID.
REQ-024 Latency: spawn_req seen at edge E0 with no x rejection -> spawn_valid high after edge E3; each rejection adds one cycle; worst case E3+MAX_RETRY-1.
REQ-025 VALID: outputs SHALL hold constant; spawn_ack=1 at an edge -> IDLE, spawn_valid low after that edge.
REQ-026 spawn_req and spawn_ack both high in VALID: ack wins, -> IDLE; the request is not queued and must be held or reissued to start a new spawn.
REQ-027 spawn_ack outside VALID SHALL be ignored.
REQ-028 duck_x/y/dir/speed SHALL retain last values in IDLE (not cleared on ack).

Reset
REQ-029 reset=0 at an edge, in any state: state -> IDLE, retry count -> 0, duck_x=0, duck_y=0, duck_dir=00, duck_speed=1, spawn_valid=0, busy=0.
REQ-030 Reset mid-sequence SHALL abandon the spawn; a spawn_req concurrent with reset is dropped.
REQ-031 All registers SHALL have defined values after one reset edge; no asynchronous paths.

Verification
REQ-032 Reset, then spawn_req pulse; rng_value sequence 0x0123, 0x0040, 0x0011 -> after E3: duck_x=0x123 (291), duck_y=32+0x40=96, duck_dir=01, duck_speed=4, spawn_valid=1, busy=1.
REQ-033 rng_value sequence 0x03FF, 0x0300, 0x0100, 0x0005, 0x0000 -> two rejections, duck_x=256, duck_y=37, duck_dir=00, duck_speed=1 (zero remap); spawn_valid after E5.
REQ-034 rng_value held at 0xFFFF -> 8 rejections, duck_x=511 fallback; duck_y=287, duck_dir=11, duck_speed=7; spawn_valid after E10 (E3+MAX_RETRY-1).
REQ-035 In VALID hold spawn_ack=0 for 20 cycles with rng toggling -> outputs unchanged; assert spawn_ack with spawn_req=1 -> IDLE next edge, spawn_valid=0, no new spawn started.
REQ-036 Assert reset=0 while in SAMPLE_Y -> next edge busy=0, spawn_valid=0, duck_x=0; release reset, new spawn_req completes normally.
REQ-037 Random soak: 10k spawns with the real xorshift_rng -> every duck_x <= 608, duck_y in 32..287, duck_speed in 1..7.
